// File: rtl/cnt_watch.sv
// Watches an up/down counter stage: checks each step against the registered step code,
// flags wraps and counts them. Optional min/max range tracker enabled by CNT_WATCH_RANGE_EN.
module cnt_watch #(
    parameter int N  = 4,
    parameter int Nc = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [Nc-1:0] ctrl,
    input  logic [N-1:0]  cnt,
    input  logic          clr,
    output logic [N-1:0]  delta,
    output logic          valid,
    output logic          wrap_up,
    output logic          wrap_dn,
    output logic [7:0]    wrap_cnt,
    output logic          step_err,
    output logic [N-1:0]  cnt_min,
    output logic [N-1:0]  cnt_max
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PRIMED,
        S_CHECK,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [N-1:0] r_prev;
    logic [1:0]   r_ctrl_q;
    logic [N-1:0] r_delta;
    logic         r_valid;
    logic         r_wrap_up;
    logic         r_wrap_dn;
    logic [7:0]   r_wrap_cnt;
    logic         r_step_err;

    logic [N-1:0] w_delta;
    logic [N-1:0] w_exp;
    logic         w_live;
    logic         w_err;
    logic         w_up;
    logic         w_dn;
    logic         w_step_err_next;

    // Expected step, sign-extended to N bits; only the low two code bits matter.
    always_comb begin
        w_exp = '0;
        case (r_ctrl_q)
            2'b00:   w_exp = '0;
            2'b01:   w_exp = N'(1);
            2'b10:   w_exp = {{(N-1){1'b1}}, 1'b0};
            default: w_exp = '1;
        endcase
    end

    assign w_delta = cnt - r_prev;
    assign w_live  = (r_state == S_CHECK) || (r_state == S_FAULT);
    assign w_err   = w_live && (w_delta != w_exp);
    assign w_up    = w_live && (r_ctrl_q == 2'b01) && (cnt < r_prev);
    assign w_dn    = w_live && r_ctrl_q[1] && (cnt > r_prev);

    always_comb begin
        w_state_next    = r_state;
        w_step_err_next = r_step_err;
        case (r_state)
            S_EMPTY:  w_state_next = S_PRIMED;
            S_PRIMED: w_state_next = S_CHECK;
            S_CHECK:  if (w_err) w_state_next = S_FAULT;
            default:  if (clr && !w_err) w_state_next = S_CHECK;
        endcase
        // A fresh error outranks a simultaneous clear.
        if (w_err)
            w_step_err_next = 1'b1;
        else if (clr)
            w_step_err_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_prev     <= '0;
            r_ctrl_q   <= '0;
            r_delta    <= '0;
            r_valid    <= 1'b0;
            r_wrap_up  <= 1'b0;
            r_wrap_dn  <= 1'b0;
            r_wrap_cnt <= '0;
            r_step_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prev     <= cnt;
            r_ctrl_q   <= ctrl[1:0];
            r_step_err <= w_step_err_next;
            r_wrap_up  <= w_up;
            r_wrap_dn  <= w_dn;
            // Priming sample already has a valid previous value, so delta is meaningful from here.
            if (r_state != S_EMPTY) begin
                r_delta <= w_delta;
                r_valid <= 1'b1;
            end
            if (clr)
                r_wrap_cnt <= '0;
            else if ((w_up || w_dn) && (r_wrap_cnt != 8'hFF))
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign delta    = r_delta;
    assign valid    = r_valid;
    assign wrap_up  = r_wrap_up;
    assign wrap_dn  = r_wrap_dn;
    assign wrap_cnt = r_wrap_cnt;
    assign step_err = r_step_err;

`ifdef CNT_WATCH_RANGE_EN
    logic [N-1:0] r_cnt_min;
    logic [N-1:0] r_cnt_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_min <= '1;
            r_cnt_max <= '0;
        end else if (clr) begin
            r_cnt_min <= '1;
            r_cnt_max <= '0;
        end else if (r_state != S_EMPTY) begin
            if (cnt < r_cnt_min) r_cnt_min <= cnt;
            if (cnt > r_cnt_max) r_cnt_max <= cnt;
        end
    end

    assign cnt_min = r_cnt_min;
    assign cnt_max = r_cnt_max;
`else
    assign cnt_min = '0;
    assign cnt_max = '0;
`endif

endmodule

// File: tb/tb_cnt_watch.sv
// Directed bench for cnt_watch: drives a modelled counter stage and checks
// delta, wrap pulses/count, fault handling, clear, reset and the range tracker.
module tb_cnt_watch;

    localparam int N  = 4;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] ctrl;
    logic [N-1:0]  cnt;
    logic          clr;
    logic [N-1:0]  delta;
    logic          valid;
    logic          wrap_up;
    logic          wrap_dn;
    logic [7:0]    wrap_cnt;
    logic          step_err;
    logic [N-1:0]  cnt_min;
    logic [N-1:0]  cnt_max;

    int checks = 0;
    int errors = 0;
    int ups;
    int dns;

    logic [1:0]   codes [4];
    logic [N-1:0] steps [4];
    logic [N-1:0] prev_step;

    cnt_watch #(.N(N), .Nc(NC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (ctrl),
        .cnt      (cnt),
        .clr      (clr),
        .delta    (delta),
        .valid    (valid),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn),
        .wrap_cnt (wrap_cnt),
        .step_err (step_err),
        .cnt_min  (cnt_min),
        .cnt_max  (cnt_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    function automatic logic [N-1:0] step_of(input logic [1:0] c);
        case (c)
            2'b00:   return 4'h0;
            2'b01:   return 4'h1;
            2'b10:   return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    // One clock of the counter stage: it applies the code it sampled on this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt = cnt + step_of(ctrl[1:0]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},    valid,    0);
        check({tag, "_delta"},    delta,    0);
        check({tag, "_wrap_up"},  wrap_up,  0);
        check({tag, "_wrap_dn"},  wrap_dn,  0);
        check({tag, "_wrap_cnt"}, wrap_cnt, 0);
        check({tag, "_step_err"}, step_err, 0);
`ifdef CNT_WATCH_RANGE_EN
        check({tag, "_min"}, cnt_min, 4'hF);
        check({tag, "_max"}, cnt_max, 4'h0);
`else
        check({tag, "_min"}, cnt_min, 4'h0);
        check({tag, "_max"}, cnt_max, 4'h0);
`endif
    endtask

    task automatic do_reset(input logic [N-1:0] c0, input logic [1:0] k0, input string tag);
        rst_n = 1'b0;
        clr   = 1'b0;
        cnt   = c0;
        ctrl  = k0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        codes = '{2'b01, 2'b11, 2'b00, 2'b10};
        steps = '{4'h1, 4'hF, 4'h0, 4'hE};

        // Count up by one through a wrap.
        do_reset(4'd0, 2'b01, "rst1");
        tick();
        check("up_primed_valid", valid, 0);
        tick();
        check("up_first_valid", valid, 1);
        check("up_first_delta", delta, 4'h1);
        ups = 0;
        repeat (20) begin
            tick();
            check("up_delta", delta, 4'h1);
            ups = ups + int'(wrap_up);
        end
        check("up_wrap_pulses", ups, 1);
        check("up_wrap_cnt", wrap_cnt, 1);
        check("up_step_err", step_err, 0);

        // Count down by two from 0 once checking is live.
        do_reset(4'd0, 2'b00, "rst2");
        tick();
        ctrl = 2'b10;
        tick();
        check("dn_first_valid", valid, 1);
        check("dn_first_delta", delta, 4'h0);
        dns = 0;
        repeat (8) begin
            tick();
            check("dn_delta", delta, 4'hE);
            dns = dns + int'(wrap_dn);
        end
        check("dn_wrap_pulses", dns, 1);
        check("dn_wrap_cnt", wrap_cnt, 1);
        check("dn_step_err", step_err, 0);

        // Code changes: delta follows with a one-sample lag and no error.
        prev_step = 4'hE;
        for (int p = 0; p < 4; p++) begin
            ctrl = codes[p];
            for (int i = 0; i < 50; i++) begin
                tick();
                check("seq_delta", delta, (i == 0) ? prev_step : steps[p]);
            end
            prev_step = steps[p];
        end
        check("seq_step_err", step_err, 0);

        // Step error 3->7, sticky fault, clear, then error-vs-clear priority.
        do_reset(4'd0, 2'b01, "rst3");
        tick();
        tick();
        tick();
        tick();
        cnt = 4'd7;
        check("err_before", step_err, 0);
        tick();
        check("err_set", step_err, 1);
        check("err_delta", delta, 4'h4);
        check("err_valid", valid, 1);
        tick();
        check("err_sticky", step_err, 1);
        check("err_delta_runs", delta, 4'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_cleared", step_err, 0);
        tick();
        check("err_check_state", step_err, 0);
        cnt = cnt + 4'd3;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_beats_clr", step_err, 1);
        tick();
        check("err_fault_held", step_err, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_cleared2", step_err, 0);

        // Wrap counter saturation and clear.
        do_reset(4'd0, 2'b01, "rst4");
        tick();
        tick();
        repeat (160) tick();
        check("sat_wrap_cnt_10", wrap_cnt, 10);
        repeat (4800) tick();
        check("sat_wrap_cnt_255", wrap_cnt, 255);
        check("sat_step_err", step_err, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_cleared", wrap_cnt, 0);

        // Asynchronous reset mid-run, recovery and range tracking.
        repeat (16) tick();
        check("mid_wrap_cnt", wrap_cnt, 1);
        cnt = cnt + 4'd5;
        tick();
        check("mid_step_err", step_err, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        cnt  = 4'd4;
        ctrl = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rec_valid_1", valid, 0);
        tick();
        check("rec_valid_2", valid, 1);
        check("rec_delta", delta, 4'h1);
        repeat (4) tick();
`ifdef CNT_WATCH_RANGE_EN
        check("range_min", cnt_min, 4'h5);
        check("range_max", cnt_max, 4'h9);
`else
        check("range_min", cnt_min, 4'h0);
        check("range_max", cnt_max, 4'h0);
`endif
        clr = 1'b1;
        tick();
        clr = 1'b0;
`ifdef CNT_WATCH_RANGE_EN
        check("range_clr_min", cnt_min, 4'hF);
        check("range_clr_max", cnt_max, 4'h0);
`else
        check("range_clr_min", cnt_min, 4'h0);
        check("range_clr_max", cnt_max, 4'h0);
`endif
        check("rec_step_err", step_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
